// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants for the register file and its pending-write scoreboard.
// Optional forwarding build: define REGFILE_BYPASS_EN.
package reg_file_scoreboard_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_file_scoreboard_sb.sv
// Pending-write bitmap plus RAW/WAW stall generation.
// With REGFILE_BYPASS_EN a same-cycle writeback masks its busy bit.
module reg_file_scoreboard_sb
  import reg_file_scoreboard_pkg::*;
(
  input  logic              clk_,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] rs_addr_,
  input  logic [ADDR_W-1:0] rt_addr_,
  input  logic              issue_valid_,
  input  logic              issue_dst_valid_,
  input  logic [ADDR_W-1:0] issue_dst_,
  input  logic              wb_valid_,
  input  logic [ADDR_W-1:0] wb_dst_,
  output logic              stall_,
  output logic [NREG-1:0]   busy_vec_
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] eb_vec;
  logic            accept;

  // Effective busy: what a consumer must wait on this cycle
  always_comb begin
    eb_vec = busy_q;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid_) eb_vec[wb_dst_] = 1'b0;
`else
    eb_vec = busy_q;
`endif
  end

  // Hazard check and issue acceptance
  always_comb begin
    stall_ = issue_valid_ &
             (eb_vec[rs_addr_] | eb_vec[rt_addr_] |
              (issue_dst_valid_ & eb_vec[issue_dst_]));
    accept = issue_valid_ & ~stall_ & issue_dst_valid_ &
             (issue_dst_ != REG_ZERO);
  end

  // Next bitmap: clear on writeback, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_) busy_d[wb_dst_] = 1'b0;
    if (accept) busy_d[issue_dst_] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Bitmap register, dropped entirely on reset
  always_ff @(posedge clk_) begin
    if (!rst_) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec_ = busy_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// 32x32 register file with two async read ports and one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic              clk_,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] rs_addr_,
  input  logic [ADDR_W-1:0] rt_addr_,
  output logic [DATA_W-1:0] rs_data_,
  output logic [DATA_W-1:0] rt_data_,
  input  logic              issue_valid_,
  input  logic              issue_dst_valid_,
  input  logic [ADDR_W-1:0] issue_dst_,
  output logic              stall_,
  input  logic              wb_valid_,
  input  logic [ADDR_W-1:0] wb_dst_,
  input  logic [DATA_W-1:0] wb_data_,
  output logic [NREG-1:0]   busy_vec_
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wb_we;

  assign wb_we = wb_valid_ & (wb_dst_ != REG_ZERO);

  // Storage: r0 is never written so it stays zero
  always_ff @(posedge clk_) begin
    if (!rst_) regs <= '{default: '0};
    else if (wb_we) regs[wb_dst_] <= wb_data_;
  end

  // rs read port
  always_comb begin
    rs_data_ = regs[rs_addr_];
    if (rs_addr_ == REG_ZERO) rs_data_ = '0;
`ifdef REGFILE_BYPASS_EN
    else if (wb_we && wb_dst_ == rs_addr_) rs_data_ = wb_data_;
`endif
  end

  // rt read port
  always_comb begin
    rt_data_ = regs[rt_addr_];
    if (rt_addr_ == REG_ZERO) rt_data_ = '0;
`ifdef REGFILE_BYPASS_EN
    else if (wb_we && wb_dst_ == rt_addr_) rt_data_ = wb_data_;
`endif
  end

  reg_file_scoreboard_sb u_sb (
    .clk_            (clk_),
    .rst_            (rst_),
    .rs_addr_        (rs_addr_),
    .rt_addr_        (rt_addr_),
    .issue_valid_    (issue_valid_),
    .issue_dst_valid_(issue_dst_valid_),
    .issue_dst_      (issue_dst_),
    .wb_valid_       (wb_valid_),
    .wb_dst_         (wb_dst_),
    .stall_          (stall_),
    .busy_vec_       (busy_vec_)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard; expectations queued by stimulus,
// compared by a negedge monitor. Follows REGFILE_BYPASS_EN if defined.
module tb_reg_file_scoreboard;

  localparam int S_RS = 0;
  localparam int S_RT = 1;
  localparam int S_ST = 2;
  localparam int S_BV = 3;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        clk_ = 1'b0;
  logic        rst_;
  logic [4:0]  rs_addr_, rt_addr_, issue_dst_, wb_dst_;
  logic [31:0] rs_data_, rt_data_, wb_data_, busy_vec_;
  logic        issue_valid_, issue_dst_valid_, wb_valid_, stall_;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  reg_file_scoreboard dut (
    .clk_            (clk_),
    .rst_            (rst_),
    .rs_addr_        (rs_addr_),
    .rt_addr_        (rt_addr_),
    .rs_data_        (rs_data_),
    .rt_data_        (rt_data_),
    .issue_valid_    (issue_valid_),
    .issue_dst_valid_(issue_dst_valid_),
    .issue_dst_      (issue_dst_),
    .stall_          (stall_),
    .wb_valid_       (wb_valid_),
    .wb_dst_         (wb_dst_),
    .wb_data_        (wb_data_),
    .busy_vec_       (busy_vec_)
  );

  always #5 clk_ = ~clk_;

  // Monitor: outputs are settled at negedge; compare every queued item
  always @(negedge clk_) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      unique case (e.sel)
        S_RS:    act = rs_data_;
        S_RT:    act = rt_data_;
        S_ST:    act = {31'b0, stall_};
        default: act = busy_vec_;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_);
    #1;
  endtask

  task automatic idle();
    issue_valid_     = 1'b0;
    issue_dst_valid_ = 1'b0;
    issue_dst_       = '0;
    wb_valid_        = 1'b0;
    wb_dst_          = '0;
    wb_data_         = '0;
    rs_addr_         = '0;
    rt_addr_         = '0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic dv, input logic [4:0] d);
    issue_valid_     = 1'b1;
    rs_addr_         = rs;
    rt_addr_         = rt;
    issue_dst_valid_ = dv;
    issue_dst_       = d;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] v);
    wb_valid_ = 1'b1;
    wb_dst_   = d;
    wb_data_  = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b0;
    idle();
    step(); step(); step();
    // Reset behaviour
    rst_ = 1'b1;
    wb(5, 32'hDEADBEEF);
    expect_v("busy_after_reset", S_BV, 32'h0);
    step();
    idle(); rs_addr_ = 5;
    expect_v("r5_written", S_RS, 32'hDEADBEEF);
    step();
    rst_ = 1'b0;
    wb(6, 32'h11111111);
    issue(0, 0, 1'b1, 8);
    step();
    rst_ = 1'b1;
    idle(); rs_addr_ = 5; rt_addr_ = 6;
    expect_v("r5_cleared", S_RS, 32'h0);
    expect_v("wb_in_reset_ignored", S_RT, 32'h0);
    expect_v("busy_reset", S_BV, 32'h0);
    step();
    // RAW on r7
    idle(); issue(1, 2, 1'b1, 7);
    expect_v("issue7_stall", S_ST, 32'h0);
    expect_v("issue7_busy_pre", S_BV, 32'h0);
    step();
    idle(); issue(7, 2, 1'b0, 0);
    expect_v("raw7_stall", S_ST, 32'h1);
    expect_v("busy7_set", S_BV, 32'h80);
    step();
    expect_v("raw7_stall_hold", S_ST, 32'h1);
    step();
    wb(7, 32'h12345678);
    expect_v("raw7_wb_cycle", S_ST, BYP ? 32'h0 : 32'h1);
    step();
    idle(); issue(7, 2, 1'b0, 0);
    expect_v("raw7_release", S_ST, 32'h0);
    expect_v("r7_data", S_RS, 32'h12345678);
    expect_v("busy7_clear", S_BV, 32'h0);
    step();
    // WAW on r9
    idle(); issue(0, 0, 1'b1, 9);
    expect_v("issue9_stall", S_ST, 32'h0);
    step();
    expect_v("waw9_stall", S_ST, 32'h1);
    expect_v("busy9_set", S_BV, 32'h200);
    step();
    expect_v("waw9_stall_hold", S_ST, 32'h1);
    expect_v("busy9_unchanged", S_BV, 32'h200);
    step();
    wb(9, 32'h00000099);
    expect_v("waw9_wb_cycle", S_ST, BYP ? 32'h0 : 32'h1);
    step();
    idle(); issue(0, 0, 1'b1, 9);
    expect_v("waw9_after_wb", S_ST, BYP ? 32'h1 : 32'h0);
    expect_v("busy9_after_wb", S_BV, BYP ? 32'h200 : 32'h0);
    step();
    idle(); rs_addr_ = 9;
    expect_v("busy9_reissued", S_BV, 32'h200);
    expect_v("r9_data", S_RS, 32'h99);
    step();
    idle(); wb(9, 32'h0);
    step();
    idle();
    expect_v("busy_idle", S_BV, 32'h0);
    step();
    // Register zero
    wb(0, 32'hFFFFFFFF);
    issue(0, 0, 1'b1, 0);
    expect_v("r0_stall", S_ST, 32'h0);
    expect_v("r0_no_fwd", S_RS, 32'h0);
    step();
    idle();
    expect_v("r0_read", S_RS, 32'h0);
    expect_v("r0_busy", S_BV, 32'h0);
    step();
    // Same-cycle writeback vs consumer
    issue(0, 0, 1'b1, 3);
    step();
    idle(); issue(3, 0, 1'b0, 0);
    wb(3, 32'hA5A5A5A5);
    expect_v("byp3_stall", S_ST, BYP ? 32'h0 : 32'h1);
    expect_v("byp3_data", S_RS, BYP ? 32'hA5A5A5A5 : 32'h0);
    expect_v("byp3_busy", S_BV, 32'h8);
    step();
    idle(); issue(3, 0, 1'b0, 0);
    expect_v("byp3_next_stall", S_ST, 32'h0);
    expect_v("byp3_next_data", S_RS, 32'hA5A5A5A5);
    expect_v("byp3_next_busy", S_BV, 32'h0);
    step();
    // Same-cycle set and clear of r4
    idle(); issue(0, 0, 1'b1, 4);
    step();
    wb(4, 32'h00000044);
    expect_v("sc4_stall", S_ST, BYP ? 32'h0 : 32'h1);
    expect_v("sc4_busy", S_BV, 32'h10);
    step();
    idle(); rt_addr_ = 4;
    expect_v("sc4_data", S_RT, 32'h44);
    expect_v("sc4_busy_after", S_BV, BYP ? 32'h10 : 32'h0);
    step();
    @(negedge clk_);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
